// File: rtl/unidade_execucao.sv
// unidade_execucao
// Single-issue execution unit fed by a reservation station. A dispatched
// instruction (opcode, registers, station tag and both operand values) is
// captured on accept, executed as ADD/SUB/MUL/MULH with a fixed per-class
// latency, and then reported with a one-cycle completion broadcast.
//
// Parameters:
//   LAT_ADD  cycles from accept to done for ADD/SUB/unknown opcodes (1..15)
//   LAT_MUL  cycles from accept to done for MUL/MULH (1..15)
// Ports:
//   Clock         in   rising-edge clock
//   Reset         in   synchronous active-high reset
//   instInEnable  in   dispatch strobe
//   instIn[15:0]  in   instruction: [3:0] opcode, [12:10] Rz, [9:7] Ry, [6:4] Rx
//   tagIn[2:0]    in   station entry of the dispatched instruction
//   rxVal[15:0]   in   Rx operand value
//   ryVal[15:0]   in   Ry operand value
//   disponivel    out  unit can accept an instruction this cycle
//   done          out  one-cycle completion pulse
//   tagOut[2:0]   out  tag of the completing instruction
//   doneInst[15:0] out completing instruction word
//   dout[15:0]    out  result
//   overrun       out  one-cycle pulse after a dispatch attempted while busy
module unidade_execucao #(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        instInEnable,
  input  logic [15:0] instIn,
  input  logic [2:0]  tagIn,
  input  logic [15:0] rxVal,
  input  logic [15:0] ryVal,
  output logic        disponivel,
  output logic        done,
  output logic [2:0]  tagOut,
  output logic [15:0] doneInst,
  output logic [15:0] dout,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter preload is latency minus one: the EXEC cycle that sees cnt==0
  // is the last one before completion.
  localparam logic [3:0] CNT_ADD = 4'(LAT_ADD - 1);
  localparam logic [3:0] CNT_MUL = 4'(LAT_MUL - 1);

  function automatic logic is_mul(input logic [3:0] op);
    return (op == 4'b0100) || (op == 4'b0101);
  endfunction

  function automatic logic [15:0] alu(input logic [3:0] op,
                                      input logic [15:0] ry,
                                      input logic [15:0] rx);
    logic [31:0] prod;
    logic [15:0] res;
    prod = {16'd0, ry} * {16'd0, rx};
    case (op)
      4'b0000: res = ry + rx;
      4'b0001: res = ry - rx;
      4'b0100: res = prod[15:0];
      4'b0101: res = prod[31:16];
      // Unknown opcodes still complete so the station entry is released.
      default: res = 16'd0;
    endcase
    return res;
  endfunction

  state_t      state_r, state_nx;
  logic [3:0]  cnt_r, cnt_nx;
  logic [15:0] inst_r, rx_r, ry_r;
  logic [2:0]  tag_r;
  logic        disp_r, done_r, overrun_r;
  logic [2:0]  tag_out_r;
  logic [15:0] done_inst_r, dout_r;
  logic        accept_s, finish_s;

  assign accept_s   = instInEnable && disp_r;
  assign disponivel = disp_r;
  assign done       = done_r;
  assign tagOut     = tag_out_r;
  assign doneInst   = done_inst_r;
  assign dout       = dout_r;
  assign overrun    = overrun_r;

  // Next-state, counter and completion decode.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    finish_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          state_nx = EXEC;
          cnt_nx   = is_mul(instIn[3:0]) ? CNT_MUL : CNT_ADD;
        end else begin
          state_nx = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == 4'd0) begin
          state_nx = DONE;
          finish_s = 1'b1;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, operand capture, result and registered status outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      inst_r      <= 16'd0;
      rx_r        <= 16'd0;
      ry_r        <= 16'd0;
      tag_r       <= 3'd0;
      disp_r      <= 1'b1;
      done_r      <= 1'b0;
      overrun_r   <= 1'b0;
      tag_out_r   <= 3'd0;
      done_inst_r <= 16'd0;
      dout_r      <= 16'd0;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      disp_r    <= (state_nx != EXEC);
      done_r    <= finish_s;
      // A strobe while executing is dropped; flag it for one cycle.
      overrun_r <= instInEnable && (state_r == EXEC);
      if (accept_s) begin
        inst_r <= instIn;
        tag_r  <= tagIn;
        rx_r   <= rxVal;
        ry_r   <= ryVal;
      end
      if (finish_s) begin
        dout_r      <= alu(inst_r[3:0], ry_r, rx_r);
        tag_out_r   <= tag_r;
        done_inst_r <= inst_r;
      end
    end
  end

endmodule

// File: tb/tb_unidade_execucao.sv
module tb_unidade_execucao;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        instInEnable = 1'b0;
  logic [15:0] instIn = 16'd0;
  logic [2:0]  tagIn = 3'd0;
  logic [15:0] rxVal = 16'd0;
  logic [15:0] ryVal = 16'd0;
  logic        disponivel, done, overrun;
  logic [2:0]  tagOut;
  logic [15:0] doneInst, dout;

  int total = 0;
  int bad = 0;

  unidade_execucao #(.LAT_ADD(2), .LAT_MUL(4)) dut (
    .Clock(Clock), .Reset(Reset), .instInEnable(instInEnable),
    .instIn(instIn), .tagIn(tagIn), .rxVal(rxVal), .ryVal(ryVal),
    .disponivel(disponivel), .done(done), .tagOut(tagOut),
    .doneInst(doneInst), .dout(dout), .overrun(overrun)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Drive one dispatch across a single edge, then scramble the inputs so
  // any late use of them shows up in the result.
  task automatic dispatch(input logic [15:0] inst, input logic [2:0] tag,
                          input logic [15:0] ry, input logic [15:0] rx);
    instIn = inst; tagIn = tag; ryVal = ry; rxVal = rx; instInEnable = 1'b1;
    tick;
    instInEnable = 1'b0;
    instIn = 16'hFFFF; tagIn = 3'd0; ryVal = 16'hA5A5; rxVal = 16'h5A5A;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick;
    tick;
    Reset = 1'b0;
    total++;
    if ({disponivel, done, overrun} !== 3'b100) begin
      bad++; $display("FAIL reset_status got=%b want=100", {disponivel, done, overrun});
    end
    total++;
    if ({tagOut, doneInst, dout} !== {3'd0, 16'd0, 16'd0}) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0/0/0", tagOut, doneInst, dout);
    end
  endtask

  task automatic test_opcodes;
    logic [15:0] v_inst [5] = '{16'h0530, 16'h0531, 16'h0534, 16'h0535, 16'h0537};
    logic [2:0]  v_tag  [5] = '{3'd3, 3'd5, 3'd2, 3'd6, 3'd7};
    logic [15:0] v_ry   [5] = '{16'h7FFF, 16'h0000, 16'h1234, 16'h1234, 16'h1234};
    logic [15:0] v_rx   [5] = '{16'h0001, 16'h0001, 16'h0100, 16'h0100, 16'h0100};
    logic [15:0] v_exp  [5] = '{16'h8000, 16'hFFFF, 16'h3400, 16'h0012, 16'h0000};
    int          v_lat  [5] = '{2, 2, 4, 4, 2};
    for (int i = 0; i < 5; i++) begin
      dispatch(v_inst[i], v_tag[i], v_ry[i], v_rx[i]);
      for (int c = 1; c < v_lat[i]; c++) begin
        total++;
        if ({disponivel, done} !== 2'b00) begin
          bad++; $display("FAIL op%0d_busy_c%0d got=%b want=00", i, c, {disponivel, done});
        end
        tick;
      end
      total++;
      if ({disponivel, done} !== 2'b00) begin
        bad++; $display("FAIL op%0d_last_busy got=%b want=00", i, {disponivel, done});
      end
      tick;
      total++;
      if ({disponivel, done} !== 2'b11) begin
        bad++; $display("FAIL op%0d_done got=%b want=11", i, {disponivel, done});
      end
      total++;
      if ({tagOut, doneInst, dout} !== {v_tag[i], v_inst[i], v_exp[i]}) begin
        bad++; $display("FAIL op%0d_result got=%h/%h/%h want=%h/%h/%h", i,
                        tagOut, doneInst, dout, v_tag[i], v_inst[i], v_exp[i]);
      end
      tick;
      total++;
      if ({disponivel, done} !== 2'b10) begin
        bad++; $display("FAIL op%0d_after got=%b want=10", i, {disponivel, done});
      end
    end
  endtask

  task automatic test_overrun;
    dispatch(16'h0530, 3'd4, 16'h0005, 16'h0006);
    tick;
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_early got=%b want=0", overrun);
    end
    // Second EXEC cycle: this strobe must be dropped.
    instIn = 16'h0531; tagIn = 3'd1; ryVal = 16'h0009; rxVal = 16'h0002; instInEnable = 1'b1;
    tick;
    instInEnable = 1'b0;
    total++;
    if ({done, overrun} !== 2'b11) begin
      bad++; $display("FAIL ovr_pulse got=%b want=11", {done, overrun});
    end
    total++;
    if ({tagOut, dout} !== {3'd4, 16'h000B}) begin
      bad++; $display("FAIL ovr_result got=%h/%h want=4/000b", tagOut, dout);
    end
    tick;
    total++;
    if ({disponivel, done, overrun} !== 3'b100) begin
      bad++; $display("FAIL ovr_after got=%b want=100", {disponivel, done, overrun});
    end
    tick;
    total++;
    if ({disponivel, done} !== 2'b10) begin
      bad++; $display("FAIL ovr_dropped got=%b want=10", {disponivel, done});
    end
  endtask

  task automatic test_back_to_back;
    dispatch(16'h0530, 3'd1, 16'h0010, 16'h0020);
    tick;
    tick;
    total++;
    if ({done, tagOut, dout} !== {1'b1, 3'd1, 16'h0030}) begin
      bad++; $display("FAIL b2b_first got=%b/%h/%h want=1/1/0030", done, tagOut, dout);
    end
    // Dispatch during the DONE cycle.
    dispatch(16'h0531, 3'd2, 16'h0100, 16'h0001);
    total++;
    if ({disponivel, done, overrun} !== 3'b000) begin
      bad++; $display("FAIL b2b_accept got=%b want=000", {disponivel, done, overrun});
    end
    tick;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL b2b_wait got=%b want=0", done);
    end
    tick;
    total++;
    if ({done, tagOut, doneInst, dout} !== {1'b1, 3'd2, 16'h0531, 16'h00FF}) begin
      bad++; $display("FAIL b2b_second got=%b/%h/%h/%h want=1/2/0531/00ff",
                      done, tagOut, doneInst, dout);
    end
    tick;
  endtask

  task automatic test_reset_mid_seq;
    dispatch(16'h0530, 3'd3, 16'h0001, 16'h0001);
    tick;
    Reset = 1'b1;
    tick;
    tick;
    Reset = 1'b0;
    total++;
    if ({disponivel, done, overrun, tagOut, dout} !== {3'b100, 3'd0, 16'd0}) begin
      bad++; $display("FAIL rst_mid got=%b/%h/%h want=100/0/0",
                      {disponivel, done, overrun}, tagOut, dout);
    end
    for (int c = 0; c < 3; c++) begin
      tick;
      total++;
      if (done !== 1'b0) begin
        bad++; $display("FAIL rst_mid_nodone_c%0d got=%b want=0", c, done);
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    dispatch(16'h0534, 3'd6, 16'h0003, 16'h0005);
    tick;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    total++;
    if ({disponivel, done} !== 2'b10) begin
      bad++; $display("FAIL rstmul_edge got=%b want=10", {disponivel, done});
    end
    tick;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL rstmul_k3 got=%b want=0", done);
    end
    dispatch(16'h0530, 3'd5, 16'h0002, 16'h0003);
    total++;
    if ({disponivel, done} !== 2'b00) begin
      bad++; $display("FAIL rstmul_k4 got=%b want=00", {disponivel, done});
    end
    tick;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL rstmul_k5 got=%b want=0", done);
    end
    tick;
    total++;
    if ({done, tagOut, doneInst, dout} !== {1'b1, 3'd5, 16'h0530, 16'h0005}) begin
      bad++; $display("FAIL rstmul_add got=%b/%h/%h/%h want=1/5/0530/0005",
                      done, tagOut, doneInst, dout);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_opcodes;
    test_overrun;
    test_back_to_back;
    test_reset_mid_seq;
    test_reset_mid_mul;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
